rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 100 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin between the ALU and the load unit,
// a one-deep registered write port and a per-register pending-write scoreboard.
module rf_wb_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 mem_ready,
  input  logic                 rsv_valid,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic                 regWrite,
  output logic [ADDR_W-1:0]    writeAddr,
  output logic [DATA_W-1:0]    writeValue,
  output logic [2**ADDR_W-1:0] busy
);

  localparam int unsigned NumRegs = 2**ADDR_W;

  // High means the load unit wins the next tie; reset leaves it low so the ALU wins first.
  logic                 mem_prio_q, mem_prio_d;
  logic                 reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]    write_addr_q, write_addr_d;
  logic [DATA_W-1:0]    write_value_q, write_value_d;
  logic [NumRegs-1:0]   busy_q, busy_d;

  logic                 xfer;
  logic [ADDR_W-1:0]    xfer_addr;
  logic [DATA_W-1:0]    xfer_data;

  // Grant: a lone requester wins outright, a tie goes to the priority holder.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!reset) begin
      alu_ready = alu_valid && (!mem_valid || !mem_prio_q);
      mem_ready = mem_valid && (!alu_valid || mem_prio_q);
    end
  end

  // Select the accepted request and compute next state of pointer, write port and scoreboard.
  always_comb begin
    xfer          = alu_ready || mem_ready;
    xfer_addr     = mem_ready ? mem_addr : alu_addr;
    xfer_data     = mem_ready ? mem_data : alu_data;

    mem_prio_d    = mem_prio_q;
    reg_write_d   = 1'b0;
    write_addr_d  = write_addr_q;
    write_value_d = write_value_q;
    busy_d        = busy_q;

    if (xfer) begin
      mem_prio_d    = alu_ready;
      // Register 0 is hard-wired, so its write is swallowed but the port still loads.
      reg_write_d   = (xfer_addr != '0);
      write_addr_d  = xfer_addr;
      write_value_d = xfer_data;
      busy_d[xfer_addr] = 1'b0;
    end
    // Applied after the clear so a same-register reservation wins.
    if (rsv_valid && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State update with synchronous reset that drops any pending write and all reservations.
  always_ff @(posedge CLK) begin
    if (reset) begin
      mem_prio_q    <= 1'b0;
      reg_write_q   <= 1'b0;
      write_addr_q  <= '0;
      write_value_q <= '0;
      busy_q        <= '0;
    end else begin
      mem_prio_q    <= mem_prio_d;
      reg_write_q   <= reg_write_d;
      write_addr_q  <= write_addr_d;
      write_value_q <= write_value_d;
      busy_q        <= busy_d;
    end
  end

  // Drive the registered outputs.
  always_comb begin
    regWrite   = reg_write_q;
    writeAddr  = write_addr_q;
    writeValue = write_value_q;
    busy       = busy_q;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised and directed bench for rf_wb_arbiter with a queue-based scoreboard.
module tb_rf_wb_arbiter;

  logic       CLK = 1'b0;
  logic       reset;
  logic       alu_valid, mem_valid, rsv_valid;
  logic [2:0] alu_addr, mem_addr, rsv_addr;
  logic [7:0] alu_data, mem_data;
  logic       alu_ready, mem_ready;
  logic       regWrite;
  logic [2:0] writeAddr;
  logic [7:0] writeValue;
  logic [7:0] busy;

  rf_wb_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .regWrite  (regWrite),
    .writeAddr (writeAddr),
    .writeValue(writeValue),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rw;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: who won last, the pending-write set and the held write port.
  int   last_winner = 1;  // 0 = ALU, 1 = MEM; MEM so the ALU takes the first tie
  bit   pending[8];
  logic [2:0] held_a = '0;
  logic [7:0] held_d = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // One cycle of stimulus: drive, check readies against the model, push expected outputs.
  task automatic step(input logic r, input logic av, input logic [2:0] aa, input logic [7:0] ad,
                      input logic mv, input logic [2:0] ma, input logic [7:0] md,
                      input logic rv, input logic [2:0] ra);
    logic ga, gm;
    exp_t e;
    @(negedge CLK);
    reset = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md; rsv_valid = rv; rsv_addr = ra;
    #1;
    ga = 1'b0; gm = 1'b0;
    if (!r) begin
      if (av && mv) begin
        if (last_winner == 0) gm = 1'b1; else ga = 1'b1;
      end else begin
        ga = av;
        gm = mv;
      end
    end
    check("alu_ready", alu_ready, ga);
    check("mem_ready", mem_ready, gm);
    e.rw = 1'b0;
    if (r) begin
      last_winner = 1;
      foreach (pending[i]) pending[i] = 1'b0;
      held_a = '0;
      held_d = '0;
    end else begin
      if (ga || gm) begin
        last_winner = ga ? 0 : 1;
        held_a = ga ? aa : ma;
        held_d = ga ? ad : md;
        e.rw = (held_a != 0);
        pending[held_a] = 1'b0;
      end
      if (rv && ra != 0) pending[ra] = 1'b1;
    end
    e.a = held_a;
    e.d = held_d;
    for (int i = 0; i < 8; i++) e.b[i] = pending[i];
    exp_q.push_back(e);
  endtask

  // Monitor: after every rising edge, compare the registered outputs with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("regWrite", regWrite, e.rw);
        check("busy", busy, e.b);
        if (e.rw) begin
          check("writeAddr", writeAddr, e.a);
          check("writeValue", writeValue, e.d);
        end else begin
          check("writeAddr_hold", writeAddr, e.a);
          check("writeValue_hold", writeValue, e.d);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    alu_valid = 0; mem_valid = 0; rsv_valid = 0;
    alu_addr = 0; mem_addr = 0; rsv_addr = 0; alu_data = 0; mem_data = 0;

    step(1, 1, 3, 8'h11, 1, 2, 8'h22, 1, 4);  // requests during reset are refused
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 8'h5A, 0, 0, 0, 0, 0);      // lone ALU write
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 8'hA0 + 8'(i), 1, 2, 8'hB0 + 8'(i), 0, 0);
    step(0, 0, 0, 0, 1, 0, 8'hFF, 0, 0);      // write to r0 swallowed
    step(0, 1, 1, 8'h33, 1, 2, 8'h44, 0, 0);  // tie after MEM grant goes to ALU
    step(0, 0, 0, 0, 0, 0, 0, 1, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 8'h55, 0, 0, 0, 0, 0);      // completes reservation on r5
    step(0, 0, 0, 0, 0, 0, 0, 1, 4);
    step(0, 0, 0, 0, 1, 4, 8'h66, 1, 4);      // set beats clear on r4
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);          // r0 reservation ignored
    step(0, 0, 0, 0, 1, 6, 8'h77, 1, 2);      // different-register set and clear
    step(0, 1, 6, 8'h88, 0, 0, 0, 0, 0);
    step(1, 1, 7, 8'h99, 1, 7, 8'h9A, 0, 0);  // reset discards pending write
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
           ($urandom_range(0, 9) < 3), 3'($urandom));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
